sim_run_ctrl: RTL and testbench

//  Simulation run controller for the NPC core. Sequences the core (run / single-step / halt)

---
 rtl/sim_run_ctrl.sv | 115 +++++++++++
 tb/tb_sim_run_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run/step/halt sequencer, trap grading, watchdog, counters and commit record for the NPC core
module sim_run_ctrl #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 1024,
    parameter int STEP_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    output logic              core_en,
    input  logic              commit_valid,
    input  logic [XLEN-1:0]   commit_pc,
    input  logic [31:0]       commit_inst,
    input  logic              is_break,
    input  logic [XLEN-1:0]   a0,
    output logic              dbg_valid,
    output logic [XLEN-1:0]   dbg_pc,
    output logic [31:0]       dbg_inst,
    output logic              halted,
    output logic [1:0]        halt_reason,
    output logic [XLEN-1:0]   halt_code,
    output logic [XLEN-1:0]   cycle_cnt,
    output logic [XLEN-1:0]   instret
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;

    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;
    localparam logic [1:0] R_USER  = 2'b00;
    localparam logic [1:0] R_GOOD  = 2'b01;
    localparam logic [1:0] R_BAD   = 2'b10;
    localparam logic [1:0] R_TIME  = 2'b11;
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [1:0]        reason_nx;
    logic [XLEN-1:0]   code_nx;
    logic [STEP_W-1:0] rem, rem_nx;
    logic [31:0]       wd_cnt;
    logic              cmd_acc, acc, brk, wd_hit;

    assign core_en   = (state == RUN) || (state == STEP);
    assign cmd_ready = (state != HALT);
    assign halted    = (state == HALT);
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign acc       = commit_valid & core_en;
    assign brk       = acc & is_break;
    assign wd_hit    = (TIMEOUT != 0) && core_en && !acc && (wd_cnt == WD_LAST);

    // next state: host commands from IDLE; trap > watchdog > user halt > step completion while running
    always_comb begin
        state_nx  = state;
        reason_nx = halt_reason;
        code_nx   = halt_code;
        rem_nx    = rem;
        if (state == IDLE && cmd_acc) begin
            if (cmd_op == OP_RUN) state_nx = RUN;
            else if (cmd_op == OP_STEP && cmd_arg != '0) begin
                state_nx = STEP;
                rem_nx   = cmd_arg;
            end else if (cmd_op == OP_HALT) begin
                state_nx  = HALT;
                reason_nx = R_USER;
            end
        end else if (core_en) begin
            if (brk) begin
                state_nx  = HALT;
                reason_nx = (a0 == '0) ? R_GOOD : R_BAD;
                code_nx   = a0;
            end else if (wd_hit) begin
                state_nx  = HALT;
                reason_nx = R_TIME;
            end else if (cmd_acc && cmd_op == OP_HALT) begin
                state_nx  = HALT;
                reason_nx = R_USER;
            end else if (state == STEP && acc) begin
                rem_nx   = rem - 1'b1;
                state_nx = (rem == 1) ? IDLE : STEP;
            end
        end
    end

    // state, halt info, watchdog, counters and the registered commit record
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            halt_reason <= '0;
            halt_code   <= '0;
            rem         <= '0;
            wd_cnt      <= '0;
            cycle_cnt   <= '0;
            instret     <= '0;
            dbg_valid   <= 1'b0;
            dbg_pc      <= '0;
            dbg_inst    <= '0;
        end else begin
            state       <= state_nx;
            halt_reason <= reason_nx;
            halt_code   <= code_nx;
            rem         <= rem_nx;
            wd_cnt      <= (state_nx != state || acc) ? '0 : wd_cnt + 32'(core_en);
            cycle_cnt   <= cycle_cnt + XLEN'(core_en);
            instret     <= instret + XLEN'(acc);
            dbg_valid   <= acc;
            if (acc) begin
                dbg_pc   <= commit_pc;
                dbg_inst <= commit_inst;
            end
        end
    end
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed scenarios plus randomized traffic checked every cycle against a behavioural model
module tb_sim_run_ctrl;
    localparam int TO = 8;

    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready;
    logic [1:0]  cmd_op = 0;
    logic [31:0] cmd_arg = 0;
    logic        core_en, commit_valid = 0, is_break = 0;
    logic [63:0] commit_pc = 0, a0 = 0;
    logic [31:0] commit_inst = 0;
    logic        dbg_valid, halted;
    logic [63:0] dbg_pc, halt_code, cycle_cnt, instret;
    logic [31:0] dbg_inst;
    logic [1:0]  halt_reason;

    sim_run_ctrl #(.XLEN(64), .TIMEOUT(TO), .STEP_W(32)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .core_en(core_en), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .is_break(is_break), .a0(a0), .dbg_valid(dbg_valid),
        .dbg_pc(dbg_pc), .dbg_inst(dbg_inst), .halted(halted), .halt_reason(halt_reason),
        .halt_code(halt_code), .cycle_cnt(cycle_cnt), .instret(instret)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, pulses = 0;
    bit live = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: modes 0 idle, 1 run, 2 step, 3 halt
    int               m_mode, m_rsn, m_wd;
    longint unsigned  m_cyc, m_ins, m_code, m_rem, m_dpc;
    int unsigned      m_dinst;
    bit               m_dv;

    always @(posedge clk) begin
        bit en, acc, ca;
        int nm;
        if (rst) begin
            live = 1; m_mode = 0; m_rsn = 0; m_wd = 0; m_cyc = 0; m_ins = 0;
            m_code = 0; m_rem = 0; m_dv = 0; m_dpc = 0; m_dinst = 0;
        end else begin
            en  = (m_mode == 1 || m_mode == 2);
            acc = commit_valid && en;
            ca  = cmd_valid && m_mode != 3;
            nm  = m_mode;
            m_dv = acc;
            if (acc) begin m_dpc = commit_pc; m_dinst = commit_inst; end
            if (en) m_cyc++;
            if (acc) m_ins++;
            if (m_mode == 0) begin
                if (ca && cmd_op == 1) nm = 1;
                else if (ca && cmd_op == 2 && cmd_arg != 0) begin nm = 2; m_rem = cmd_arg; end
                else if (ca && cmd_op == 3) begin nm = 3; m_rsn = 0; end
            end else if (en) begin
                if (acc && is_break) begin nm = 3; m_rsn = (a0 == 0) ? 1 : 2; m_code = a0; end
                else if (!acc && m_wd + 1 >= TO) begin nm = 3; m_rsn = 3; end
                else if (ca && cmd_op == 3) begin nm = 3; m_rsn = 0; end
                else if (m_mode == 2 && acc) begin m_rem--; if (m_rem == 0) nm = 0; end
            end
            m_wd = (nm != m_mode || acc) ? 0 : (en ? m_wd + 1 : m_wd);
            m_mode = nm;
        end
    end

    // compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (live) begin
            check("core_en", 64'(core_en), 64'(m_mode == 1 || m_mode == 2));
            check("cmd_ready", 64'(cmd_ready), 64'(m_mode != 3));
            check("halted", 64'(halted), 64'(m_mode == 3));
            check("halt_reason", 64'(halt_reason), 64'(m_rsn));
            check("halt_code", halt_code, m_code);
            check("cycle_cnt", cycle_cnt, m_cyc);
            check("instret", instret, m_ins);
            check("dbg_valid", 64'(dbg_valid), 64'(m_dv));
            if (m_dv) begin
                check("dbg_pc", dbg_pc, m_dpc);
                check("dbg_inst", 64'(dbg_inst), 64'(m_dinst));
            end
            if (dbg_valid) pulses++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic quiet();
        cmd_valid = 0; commit_valid = 0; is_break = 0; a0 = 0;
    endtask

    task automatic do_reset();
        quiet(); rst = 1; tick(2); rst = 0; pulses = 0;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1; cmd_op = op; cmd_arg = arg; tick(); cmd_valid = 0;
    endtask

    task automatic commit(input bit brk, input logic [63:0] v);
        commit_valid = 1; is_break = brk; a0 = v;
        commit_pc = commit_pc + 4; commit_inst = $urandom;
    endtask

    initial begin
        // T1: run, five commits, good ebreak
        do_reset();
        check("t1_reset_ready", 64'(cmd_ready), 1);
        check("t1_reset_instret", instret, 0);
        cmd(2'b01, 0);
        check("t1_run_en", 64'(core_en), 1);
        repeat (5) begin commit(0, 64'h55); tick(); end
        commit(1, 0); tick(); quiet();
        check("t1_halted", 64'(halted), 1);
        check("t1_reason", 64'(halt_reason), 1);
        check("t1_instret", instret, 6);
        check("t1_core_en", 64'(core_en), 0);
        tick();
        check("t1_pulses", 64'(pulses), 6);
        // T2: step 3 with continuous commits, then step 0
        do_reset();
        cmd(2'b10, 3);
        commit(0, 1); tick(3); quiet();
        check("t2_core_en", 64'(core_en), 0);
        check("t2_instret", instret, 3);
        commit(0, 1); tick(); quiet();
        check("t2_idle_instret", instret, 3);
        cmd(2'b10, 0);
        check("t2_step0_en", 64'(core_en), 0);
        check("t2_step0_ready", 64'(cmd_ready), 1);
        // T3: bad trap
        do_reset();
        cmd(2'b01, 0);
        commit(1, 1); tick(); quiet();
        check("t3_reason", 64'(halt_reason), 2);
        check("t3_code", halt_code, 1);
        cmd_valid = 1; cmd_op = 2'b01; #1;
        check("t3_ready", 64'(cmd_ready), 0);
        tick(); quiet();
        check("t3_still_halted", 64'(halted), 1);
        // T4: watchdog after 8 idle run cycles
        do_reset();
        cmd(2'b01, 0);
        tick(7);
        check("t4_not_yet", 64'(halted), 0);
        tick();
        check("t4_halted", 64'(halted), 1);
        check("t4_reason", 64'(halt_reason), 3);
        check("t4_cycles", cycle_cnt, 8);
        do_reset();
        cmd(2'b01, 0);
        tick(6); commit(0, 3); tick(); quiet();
        tick(7);
        check("t4_restart_alive", 64'(halted), 0);
        tick();
        check("t4_restart_halt", 64'(halt_reason), 3);
        check("t4_restart_cycles", cycle_cnt, 15);
        // T5: ebreak beats user halt
        do_reset();
        cmd(2'b01, 0);
        commit(1, 0); cmd_valid = 1; cmd_op = 2'b11; tick(); quiet();
        check("t5_reason", 64'(halt_reason), 1);
        check("t5_code", halt_code, 0);
        check("t5_instret", instret, 1);
        // T6: reset mid-run
        do_reset();
        cmd(2'b01, 0);
        commit(0, 7); tick(100); quiet();
        check("t6_running", cycle_cnt, 100);
        rst = 1; tick(); rst = 0;
        check("t6_cycles", cycle_cnt, 0);
        check("t6_instret", instret, 0);
        check("t6_ready", 64'(cmd_ready), 1);
        check("t6_en", 64'(core_en), 0);
        commit(0, 7); tick(); quiet();
        check("t6_idle_commit", instret, 0);
        // randomized traffic, model-checked every cycle
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            int dens;
            dens = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 60 : 95);
            for (int c = 0; c < 75; c++) begin
                rst = ($urandom_range(0, 59) == 0);
                cmd_valid = ($urandom_range(0, 5) == 0);
                cmd_op = 2'($urandom_range(0, 3));
                if (cmd_op == 2'b11 && $urandom_range(0, 2) != 0) cmd_op = 2'b01;
                cmd_arg = $urandom_range(0, 5);
                commit_valid = ($urandom_range(0, 99) < dens);
                is_break = ($urandom_range(0, 39) == 0);
                a0 = $urandom_range(0, 1) ? 64'h0 : {$urandom, $urandom};
                commit_pc = {$urandom, $urandom};
                commit_inst = $urandom;
                tick();
            end
        end
        quiet(); rst = 0; tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
